pet_banked_address_decoder: RTL and testbench
=============================================

// Module: pet_banked_address_decoder
// PURPOSE
//  Registered, parametrised successor to the PET address decoder.
//  Decodes the 16-bit CPU address into RAM, I/O and chip-select outputs.
//  Adds an 8096-style expansion control register that banks $8000-$FFFF
//  into 64 KB of expansion RAM. Sits between the bus timing sequencer and
//  the RAM/PIA/VIA/CRTC selects.
// PARAMETERS
//  IO_BASE     16'hE800  base of 2 KB I/O window ($E800-$EFFF)
//  IO_SEL_LSB  4         lowest CPU address bit used as a device select
//  IO_COUNT    4         number of I/O devices (PIA1, PIA2, VIA, CRTC)
//  CTRL_ADDR   16'hFFF0  write-only expansion control register address
//  EXPANSION   1         0: register and banking removed; stock PET map only
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  cpu_strobe   in   1         1-cycle pulse; cpu_addr/cpu_we/cpu_data valid
//  cpu_addr     in   16        CPU address
//  cpu_we       in   1         1 = write cycle
//  cpu_data     in   8         write data (sampled only for CTRL_ADDR writes)
//  decode_valid out  1         1-cycle pulse, one clk after cpu_strobe
//  ram_addr     out  17        physical RAM address (64 KB base + 64 KB exp)
//  ram_enable   out  1         RAM selected
//  ram_we       out  1         registered cpu_we & ram_enable & ~is_readonly
//  io_enable    out  1         address in the I/O window
//  io_select    out  IO_COUNT  one-hot device select (0 if none)
//  is_mirrored  out  1         display RAM region ($8000-$8FFF, unbanked)
//  is_readonly  out  1         ROM region or write-protected expansion bank
// BEHAVIOUR
//  - Reset: all outputs 0, ctrl register 8'h00. Reset is async (immediate);
//    strobes during reset are ignored.
//  - Latency: outputs update on the clk edge sampling cpu_strobe=1.
//    decode_valid is high that cycle only. Outputs hold until the next strobe.
//  - Ctrl bits:
//      [7] exp_en     [6] io_peek    [5] scr_peek
//      [3] hi_sel     [2] lo_sel     [1] wp_hi     [0] wp_lo
//      [4] ignored
//  - Ctrl write: cpu_strobe & cpu_we & cpu_addr==CTRL_ADDR & EXPANSION.
//    The decode in the same cycle uses the OLD register value. The new value
//    applies from the next strobe. The decode still proceeds normally (for
//    stock ROM: ram_enable=1, readonly=1, ram_we=0).
//  - Stock map (exp_en=0):
//      $0000-$7FFF RAM
//      $8000-$8FFF RAM + is_mirrored
//      $9000-$E7FF, $F000-$FFFF RAM + is_readonly
//      I/O window: io_enable=1, ram_enable=0
//    ram_addr = {1'b0, cpu_addr}.
//  - io_select: one-hot of the MOST significant set bit in
//    cpu_addr[IO_SEL_LSB +: IO_COUNT]. No bit set -> io_select=0 with
//    io_enable=1. Example: $E830 -> 4'b0010.
//  - Banked map (exp_en=1):
//      $8000-$BFFF -> {2'b10, lo_sel, a[13:0]}, readonly=wp_lo
//      $C000-$FFFF -> {2'b11, hi_sel, a[13:0]}, readonly=wp_hi
//    is_mirrored=0 and io_enable=0 in these regions, except:
//      scr_peek=1: $8000-$8FFF uses the stock map
//      io_peek=1: the I/O window uses the stock map
//    $0000-$7FFF is unaffected.
//  - Exactly one of ram_enable/io_enable is 1 after any strobe.
// STRUCTURE
//  - pet_memmap_pkg: region bounds, ctrl bit indices, RAM_ADDR_WIDTH=17.
//  - Sub-module io_priority_select: IO_COUNT-bit MSB-first one-hot encoder.
//  - Top: ctrl register, combinational decode, output register stage.
// TESTING
//  1. Reset; strobe read $8123 -> next clk: decode_valid=1, ram_enable=1,
//     is_mirrored=1, ram_addr=17'h08123, ram_we=0.
//  2. Write $FFF0=8'h80; read $8123 -> 17'h10123, is_mirrored=0;
//     read $C456 -> 17'h18456, is_readonly=0.
//  3. Write $FFF0=8'hCF; read $E830 -> io_enable=1, io_select=4'b0010,
//     ram_enable=0. Write $C010 -> ram_addr=17'h1C010, is_readonly=1, ram_we=0.
//  4. From reset, strobe write $FFF0=8'h80 -> that decode ram_addr=17'h0FFF0,
//     is_readonly=1. Next read $9000 -> 17'h11000, is_readonly=0.
//  5. Ctrl=8'h80; pulse reset between clk edges -> outputs 0 immediately.
//     Read $C000 -> ram_addr=17'h0C000, is_readonly=1.
//  6. Sweep all 64K addresses with ctrl=0 -> matches stock map.
//     Idle clks with no strobe -> outputs hold, decode_valid=0.

Source files
------------

// File: rtl/pet_memmap_pkg.sv
// rtl/pet_memmap_pkg.sv - PET memory map bounds, expansion control fields and helpers
package pet_memmap_pkg;

  localparam int RAM_ADDR_WIDTH = 17;

  // Stock map region bounds
  localparam logic [15:0] SCREEN_BASE = 16'h8000;
  localparam logic [15:0] SCREEN_END  = 16'h8FFF;
  localparam logic [15:0] ROM_BASE    = 16'h9000;
  localparam logic [15:0] IO_SIZE     = 16'h0800;

  // Bit positions in the expansion control byte; bit 4 has no function
  localparam int CTRL_EXP_EN   = 7;
  localparam int CTRL_IO_PEEK  = 6;
  localparam int CTRL_SCR_PEEK = 5;
  localparam int CTRL_HI_SEL   = 3;
  localparam int CTRL_LO_SEL   = 2;
  localparam int CTRL_WP_HI    = 1;
  localparam int CTRL_WP_LO    = 0;

  // Only the meaningful control fields are kept, so the unused bit never reaches a flop
  typedef struct packed {
    logic exp_en;
    logic io_peek;
    logic scr_peek;
    logic hi_sel;
    logic lo_sel;
    logic wp_hi;
    logic wp_lo;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_byte(input logic [7:0] b);
    ctrl_t c;
    c.exp_en   = b[CTRL_EXP_EN];
    c.io_peek  = b[CTRL_IO_PEEK];
    c.scr_peek = b[CTRL_SCR_PEEK];
    c.hi_sel   = b[CTRL_HI_SEL];
    c.lo_sel   = b[CTRL_LO_SEL];
    c.wp_hi    = b[CTRL_WP_HI];
    c.wp_lo    = b[CTRL_WP_LO];
    return c;
  endfunction

  function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/io_priority_select.sv
// rtl/io_priority_select.sv - MSB-first one-hot encoder for I/O device selects
module io_priority_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot
);

  // Scan upward so the highest set request bit is the one left standing
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pet_banked_address_decoder.sv
// rtl/pet_banked_address_decoder.sv - registered PET address decoder with 8096-style banking
module pet_banked_address_decoder
  import pet_memmap_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'hE800,
  parameter int          IO_SEL_LSB = 4,
  parameter int          IO_COUNT   = 4,
  parameter logic [15:0] CTRL_ADDR  = 16'hFFF0,
  parameter bit          EXPANSION  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_strobe,
  input  logic [15:0]               cpu_addr,
  input  logic                      cpu_we,
  input  logic [7:0]                cpu_data,
  output logic                      decode_valid,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_enable,
  output logic                      ram_we,
  output logic                      io_enable,
  output logic [IO_COUNT-1:0]       io_select,
  output logic                      is_mirrored,
  output logic                      is_readonly
);

  localparam logic [15:0] IO_LAST = IO_BASE + IO_SIZE - 16'd1;

  ctrl_t ctrl;

  logic                      ctrl_wr;
  logic                      exp_en;
  logic                      io_hit;
  logic                      screen_hit;
  logic                      banked;
  logic [IO_COUNT-1:0]       prio_sel;
  logic [RAM_ADDR_WIDTH-1:0] d_ram_addr;
  logic                      d_ram_en;
  logic                      d_ram_we;
  logic                      d_io_en;
  logic [IO_COUNT-1:0]       d_io_sel;
  logic                      d_mir;
  logic                      d_ro;

  assign ctrl_wr    = EXPANSION && cpu_strobe && cpu_we && (cpu_addr == CTRL_ADDR);
  assign exp_en     = EXPANSION && ctrl.exp_en;
  assign io_hit     = in_range(cpu_addr, IO_BASE, IO_LAST);
  assign screen_hit = in_range(cpu_addr, SCREEN_BASE, SCREEN_END);

  // Upper half is banked unless a peek bit hands a window back to the stock map
  assign banked = exp_en && cpu_addr[15]
                  && !(ctrl.scr_peek && screen_hit)
                  && !(ctrl.io_peek && io_hit);

  io_priority_select #(.N(IO_COUNT)) u_io_sel (
    .req    (cpu_addr[IO_SEL_LSB +: IO_COUNT]),
    .onehot (prio_sel)
  );

  // Control register; the decode of the writing strobe still sees the old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (ctrl_wr) begin
      ctrl <= ctrl_from_byte(cpu_data);
    end
  end

  // Combinational decode of the current bus address against stock or banked map
  always_comb begin
    d_ram_addr = {1'b0, cpu_addr};
    d_io_en    = io_hit;
    d_ram_en   = !io_hit;
    d_mir      = screen_hit;
    d_ro       = !io_hit && (cpu_addr >= ROM_BASE);
    d_io_sel   = io_hit ? prio_sel : '0;
    if (banked) begin
      d_ram_addr = {1'b1, cpu_addr[14], cpu_addr[14] ? ctrl.hi_sel : ctrl.lo_sel,
                    cpu_addr[13:0]};
      d_io_en    = 1'b0;
      d_ram_en   = 1'b1;
      d_mir      = 1'b0;
      d_ro       = cpu_addr[14] ? ctrl.wp_hi : ctrl.wp_lo;
      d_io_sel   = '0;
    end
    d_ram_we = cpu_we && d_ram_en && !d_ro;
  end

  // Output stage: capture on strobe, hold otherwise; valid pulses for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decode_valid <= 1'b0;
      ram_addr     <= '0;
      ram_enable   <= 1'b0;
      ram_we       <= 1'b0;
      io_enable    <= 1'b0;
      io_select    <= '0;
      is_mirrored  <= 1'b0;
      is_readonly  <= 1'b0;
    end else begin
      decode_valid <= cpu_strobe;
      if (cpu_strobe) begin
        ram_addr    <= d_ram_addr;
        ram_enable  <= d_ram_en;
        ram_we      <= d_ram_we;
        io_enable   <= d_io_en;
        io_select   <= d_io_sel;
        is_mirrored <= d_mir;
        is_readonly <= d_ro;
      end
    end
  end

endmodule

// File: tb/tb_pet_banked_address_decoder.sv
// tb/tb_pet_banked_address_decoder.sv - directed self-checking bench for the banked decoder
module tb_pet_banked_address_decoder;

  logic        clk;
  logic        reset;
  logic        cpu_strobe;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_data;
  logic        decode_valid;
  logic [16:0] ram_addr;
  logic        ram_enable;
  logic        ram_we;
  logic        io_enable;
  logic [3:0]  io_select;
  logic        is_mirrored;
  logic        is_readonly;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
    logic [26:0] exp;
  } vec_t;

  pet_banked_address_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_strobe   (cpu_strobe),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_data     (cpu_data),
    .decode_valid (decode_valid),
    .ram_addr     (ram_addr),
    .ram_enable   (ram_enable),
    .ram_we       (ram_we),
    .io_enable    (io_enable),
    .io_select    (io_select),
    .is_mirrored  (is_mirrored),
    .is_readonly  (is_readonly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [26:0] got;
  assign got = {decode_valid, ram_addr, ram_enable, ram_we, io_enable, io_select,
                is_mirrored, is_readonly};

  function automatic logic [26:0] mk(input logic v, input logic [16:0] ra, input logic re,
                                     input logic rw, input logic ie, input logic [3:0] isel,
                                     input logic m, input logic ro);
    return {v, ra, re, rw, ie, isel, m, ro};
  endfunction

  // Stock map written out region by region
  function automatic logic [26:0] stock_exp(input logic [15:0] a, input logic we);
    logic io, mir, ro;
    logic [3:0] sel;
    io  = (a >= 16'hE800) && (a <= 16'hEFFF);
    mir = (a >= 16'h8000) && (a <= 16'h8FFF);
    ro  = ((a >= 16'h9000) && (a <= 16'hE7FF)) || (a >= 16'hF000);
    sel = 4'b0000;
    if (io) begin
      if (a[7])      sel = 4'b1000;
      else if (a[6]) sel = 4'b0100;
      else if (a[5]) sel = 4'b0010;
      else if (a[4]) sel = 4'b0001;
    end
    return mk(1'b1, {1'b0, a}, !io, we && !io && !ro, io, sel, mir, ro);
  endfunction

  task automatic do_strobe(input logic [15:0] a, input logic we, input logic [7:0] d);
    @(negedge clk);
    cpu_strobe = 1'b1;
    cpu_addr   = a;
    cpu_we     = we;
    cpu_data   = d;
    @(negedge clk);
    cpu_strobe = 1'b0;
    cpu_we     = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (got !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", got, 27'd0);
    end
    // strobe a ctrl write while reset is held; it must be ignored
    cpu_strobe = 1'b1; cpu_addr = 16'hFFF0; cpu_we = 1'b1; cpu_data = 8'h80;
    @(negedge clk);
    cpu_strobe = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    do_strobe(16'h8123, 1'b0, 8'h00);
    checks++;
    if (got !== mk(1, 17'h08123, 1, 0, 0, 4'b0000, 1, 0)) begin
      failures++;
      $display("FAIL reset_read_8123 got=%h exp=%h", got, mk(1, 17'h08123, 1, 0, 0, 4'b0000, 1, 0));
    end
  endtask

  task automatic test_bank_enable();
    vec_t v[3];
    v[0] = '{16'hFFF0, 1'b1, 8'h80, mk(1, 17'h0FFF0, 1, 0, 0, 4'b0000, 0, 1)};
    v[1] = '{16'h8123, 1'b0, 8'h00, mk(1, 17'h10123, 1, 0, 0, 4'b0000, 0, 0)};
    v[2] = '{16'hC456, 1'b0, 8'h00, mk(1, 17'h18456, 1, 0, 0, 4'b0000, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      do_strobe(v[i].addr, v[i].we, v[i].data);
      checks++;
      if (got !== v[i].exp) begin
        failures++;
        $display("FAIL bank_enable[%0d] addr=%h got=%h exp=%h", i, v[i].addr, got, v[i].exp);
      end
    end
  endtask

  task automatic test_peek_and_protect();
    vec_t v[10];
    // ctrl=80 at entry: this ctrl write decodes into the unprotected high bank
    v[0] = '{16'hFFF0, 1'b1, 8'hCF, mk(1, 17'h1BFF0, 1, 1, 0, 4'b0000, 0, 0)};
    v[1] = '{16'hE830, 1'b0, 8'h00, mk(1, 17'h0E830, 0, 0, 1, 4'b0010, 0, 0)};
    v[2] = '{16'hC010, 1'b1, 8'h55, mk(1, 17'h1C010, 1, 0, 0, 4'b0000, 0, 1)};
    v[3] = '{16'h8123, 1'b0, 8'h00, mk(1, 17'h14123, 1, 0, 0, 4'b0000, 0, 1)};
    v[4] = '{16'hE8F0, 1'b0, 8'h00, mk(1, 17'h0E8F0, 0, 0, 1, 4'b1000, 0, 0)};
    // switch to exp_en + scr_peek; decode still uses CF (hi_sel, wp_hi)
    v[5] = '{16'hFFF0, 1'b1, 8'hA0, mk(1, 17'h1FFF0, 1, 0, 0, 4'b0000, 0, 1)};
    v[6] = '{16'h8123, 1'b0, 8'h00, mk(1, 17'h08123, 1, 0, 0, 4'b0000, 1, 0)};
    v[7] = '{16'h9000, 1'b1, 8'h00, mk(1, 17'h11000, 1, 1, 0, 4'b0000, 0, 0)};
    v[8] = '{16'hE830, 1'b0, 8'h00, mk(1, 17'h1A830, 1, 0, 0, 4'b0000, 0, 0)};
    v[9] = '{16'h1234, 1'b1, 8'h00, mk(1, 17'h01234, 1, 1, 0, 4'b0000, 0, 0)};
    for (int i = 0; i < 10; i++) begin
      do_strobe(v[i].addr, v[i].we, v[i].data);
      checks++;
      if (got !== v[i].exp) begin
        failures++;
        $display("FAIL peek_protect[%0d] addr=%h got=%h exp=%h", i, v[i].addr, got, v[i].exp);
      end
    end
  endtask

  task automatic test_ctrl_same_cycle();
    vec_t v[2];
    pulse_reset();
    v[0] = '{16'hFFF0, 1'b1, 8'h80, mk(1, 17'h0FFF0, 1, 0, 0, 4'b0000, 0, 1)};
    v[1] = '{16'h9000, 1'b0, 8'h00, mk(1, 17'h11000, 1, 0, 0, 4'b0000, 0, 0)};
    for (int i = 0; i < 2; i++) begin
      do_strobe(v[i].addr, v[i].we, v[i].data);
      checks++;
      if (got !== v[i].exp) begin
        failures++;
        $display("FAIL ctrl_same_cycle[%0d] addr=%h got=%h exp=%h", i, v[i].addr, got, v[i].exp);
      end
    end
  endtask

  task automatic test_async_reset();
    do_strobe(16'h8123, 1'b0, 8'h00);
    checks++;
    if (got !== mk(1, 17'h10123, 1, 0, 0, 4'b0000, 0, 0)) begin
      failures++;
      $display("FAIL async_pre_read got=%h exp=%h", got, mk(1, 17'h10123, 1, 0, 0, 4'b0000, 0, 0));
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (got !== 27'd0) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h exp=%h", got, 27'd0);
    end
    #1 reset = 1'b0;
    do_strobe(16'hC000, 1'b0, 8'h00);
    checks++;
    if (got !== mk(1, 17'h0C000, 1, 0, 0, 4'b0000, 0, 1)) begin
      failures++;
      $display("FAIL async_post_read got=%h exp=%h", got, mk(1, 17'h0C000, 1, 0, 0, 4'b0000, 0, 1));
    end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (got !== mk(0, 17'h0C000, 1, 0, 0, 4'b0000, 0, 1)) begin
        failures++;
        $display("FAIL idle_hold[%0d] got=%h exp=%h", i, got, mk(0, 17'h0C000, 1, 0, 0, 4'b0000, 0, 1));
      end
    end
  endtask

  task automatic test_sweep();
    int          bad;
    logic [15:0] first_a;
    logic [26:0] first_got, first_exp, e;
    logic [15:0] a;
    bad = 0; first_a = '0; first_got = '0; first_exp = '0;
    pulse_reset();
    @(negedge clk);
    cpu_strobe = 1'b1;
    cpu_data   = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      a        = i[15:0];
      cpu_addr = a;
      cpu_we   = a[0];
      @(negedge clk);
      e = stock_exp(a, a[0]);
      if (got !== e) begin
        if (bad == 0) begin
          first_a = a; first_got = got; first_exp = e;
        end
        bad++;
      end
    end
    cpu_strobe = 1'b0;
    cpu_we     = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stock_sweep bad_addrs=%0d first=%h got=%h exp=%h", bad, first_a, first_got, first_exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cpu_strobe = 1'b0;
    cpu_addr = '0;
    cpu_we = 1'b0;
    cpu_data = '0;
    test_reset();
    test_bank_enable();
    test_peek_and_protect();
    test_ctrl_same_cycle();
    test_async_reset();
    test_idle_hold();
    test_sweep();
    test_idle_hold_after_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic test_idle_hold_after_sweep();
    // last swept address $FFFF (odd -> write, but ROM so no ram_we)
    repeat (2) @(negedge clk);
    checks++;
    if (got !== mk(0, 17'h0FFFF, 1, 0, 0, 4'b0000, 0, 1)) begin
      failures++;
      $display("FAIL idle_after_sweep got=%h exp=%h", got, mk(0, 17'h0FFFF, 1, 0, 0, 4'b0000, 0, 1));
    end
  endtask

endmodule
